// File: rtl/dense_bram_seq_ctrl.sv
// Sequencing controller for the dense-waveform BRAM wrapper: streams a waveform
// into BRAM, hands the wrapper over to generator mode for playback, then flushes.
module dense_bram_seq_ctrl #(
    parameter  int DATA_WIDTH   = 257,
    parameter  int BRAM_DEPTH   = 600,
    parameter  int FLUSH_CYCLES = 4,
    localparam int AW           = $clog2(BRAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wave_line,
    input  logic                  wave_valid,
    input  logic                  wave_last,
    output logic                  wave_ready,
    input  logic                  run,
    input  logic                  halt,
    input  logic                  dac_rdy,
    output logic [AW-1:0]         bram_addr,
    output logic [DATA_WIDTH-1:0] bram_line_in,
    output logic                  bram_we,
    output logic                  bram_en,
    output logic                  bram_gen_mode,
    output logic                  bram_rst_gen_mode,
    output logic                  bram_next,
    input  logic                  bram_valid_line_out,
    input  logic                  bram_write_rdy,
    output logic                  loaded,
    output logic                  playing,
    output logic [AW:0]           num_lines,
    output logic                  wrap,
    output logic                  err_overflow
);

    localparam int            FW         = $clog2(FLUSH_CYCLES + 1);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(BRAM_DEPTH - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOADED,
        S_PLAY,
        S_FLUSH
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           play_cnt_q, play_cnt_d;
    logic [FW-1:0]           flush_cnt_q, flush_cnt_d;
    logic [AW:0]             num_lines_q, num_lines_d;
    logic                    loaded_q, loaded_d;
    logic                    err_overflow_q, err_overflow_d;
    logic                    we_q, we_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   line_q, line_d;
    logic                    gen_mode_q, gen_mode_d;
    logic                    rst_gen_q, rst_gen_d;
    logic                    playing_q, playing_d;
    logic                    rst_dly_q;

    logic                    load_state;
    logic                    accept;
    logic                    next_fire;
    logic                    play_last;
    logic [AW-1:0]           load_addr;

    assign load_state = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_LOADED);
    assign wave_ready = bram_write_rdy && load_state && !(state_q == S_LOADED && run);
    assign accept     = wave_valid && wave_ready;
    assign next_fire  = (state_q == S_PLAY) && dac_rdy && bram_valid_line_out;
    assign play_last  = ({1'b0, play_cnt_q} == (num_lines_q - (AW+1)'(1)));
    // Any accept outside LOAD starts a fresh waveform at address 0.
    assign load_addr  = (state_q == S_LOAD) ? wr_ptr_q : '0;

    always_comb begin
        // NOTE: every _d gets a default here so no path can infer a latch.
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        play_cnt_d     = play_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        num_lines_d    = num_lines_q;
        loaded_d       = loaded_q;
        err_overflow_d = err_overflow_q;
        we_d           = 1'b0;
        addr_d         = addr_q;
        line_d         = line_q;
        gen_mode_d     = gen_mode_q;
        rst_gen_d      = rst_dly_q;
        playing_d      = playing_q;

        case (state_q)
            S_IDLE, S_LOAD, S_LOADED: begin
                if (state_q == S_LOADED && run) begin
                    state_d    = S_PLAY;
                    gen_mode_d = 1'b1;
                    playing_d  = 1'b1;
                end else if (accept) begin
                    we_d     = 1'b1;
                    addr_d   = load_addr;
                    line_d   = wave_line;
                    wr_ptr_d = load_addr + AW'(1);
                    state_d  = S_LOAD;
                    if (state_q != S_LOAD) begin
                        loaded_d       = 1'b0;
                        err_overflow_d = 1'b0;
                    end
                    // Running out of BRAM closes the waveform as if last were seen.
                    if (wave_last || load_addr == LAST_ADDR) begin
                        num_lines_d    = {1'b0, load_addr} + (AW+1)'(1);
                        loaded_d       = 1'b1;
                        err_overflow_d = !wave_last;
                        wr_ptr_d       = '0;
                        state_d        = S_LOADED;
                    end
                end
            end

            S_PLAY: begin
                if (next_fire) begin
                    play_cnt_d = play_last ? '0 : play_cnt_q + AW'(1);
                end
                if (halt || !run) begin
                    state_d     = S_FLUSH;
                    gen_mode_d  = 1'b0;
                    rst_gen_d   = 1'b1;
                    playing_d   = 1'b0;
                    flush_cnt_d = '0;
                end
            end

            S_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d     = S_LOADED;
                    play_cnt_d  = '0;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state is cleared with non-blocking assignments like every other flop update.
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            play_cnt_q     <= '0;
            flush_cnt_q    <= '0;
            num_lines_q    <= '0;
            loaded_q       <= 1'b0;
            err_overflow_q <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            line_q         <= '0;
            gen_mode_q     <= 1'b0;
            rst_gen_q      <= 1'b1;
            playing_q      <= 1'b0;
            rst_dly_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            play_cnt_q     <= play_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            num_lines_q    <= num_lines_d;
            loaded_q       <= loaded_d;
            err_overflow_q <= err_overflow_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            line_q         <= line_d;
            gen_mode_q     <= gen_mode_d;
            rst_gen_q      <= rst_gen_d;
            playing_q      <= playing_d;
            rst_dly_q      <= 1'b0;
        end
    end

    assign bram_addr         = addr_q;
    assign bram_line_in      = line_q;
    assign bram_we           = we_q;
    assign bram_en           = we_q;
    assign bram_gen_mode     = gen_mode_q;
    assign bram_rst_gen_mode = rst_gen_q;
    assign bram_next         = next_fire;
    assign wrap              = next_fire && play_last;
    assign loaded            = loaded_q;
    assign playing           = playing_q;
    assign num_lines         = num_lines_q;
    assign err_overflow      = err_overflow_q;

endmodule

// File: tb/tb_dense_bram_seq_ctrl.sv
// Directed self-checking bench for dense_bram_seq_ctrl: load, play, halt/flush,
// overflow truncation, reset during playback and single-line waveforms.
module tb_dense_bram_seq_ctrl;

    localparam int DATA_WIDTH   = 257;
    localparam int BRAM_DEPTH   = 600;
    localparam int FLUSH_CYCLES = 4;
    localparam int AW           = $clog2(BRAM_DEPTH);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DATA_WIDTH-1:0] wave_line;
    logic                  wave_valid, wave_last, wave_ready;
    logic                  run, halt, dac_rdy;
    logic [AW-1:0]         bram_addr;
    logic [DATA_WIDTH-1:0] bram_line_in;
    logic                  bram_we, bram_en, bram_gen_mode, bram_rst_gen_mode, bram_next;
    logic                  bram_valid_line_out, bram_write_rdy;
    logic                  loaded, playing, wrap, err_overflow;
    logic [AW:0]           num_lines;

    int n_pass  = 0;
    int n_total = 0;

    dense_bram_seq_ctrl #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BRAM_DEPTH  (BRAM_DEPTH),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .wave_line          (wave_line),
        .wave_valid         (wave_valid),
        .wave_last          (wave_last),
        .wave_ready         (wave_ready),
        .run                (run),
        .halt               (halt),
        .dac_rdy            (dac_rdy),
        .bram_addr          (bram_addr),
        .bram_line_in       (bram_line_in),
        .bram_we            (bram_we),
        .bram_en            (bram_en),
        .bram_gen_mode      (bram_gen_mode),
        .bram_rst_gen_mode  (bram_rst_gen_mode),
        .bram_next          (bram_next),
        .bram_valid_line_out(bram_valid_line_out),
        .bram_write_rdy     (bram_write_rdy),
        .loaded             (loaded),
        .playing            (playing),
        .num_lines          (num_lines),
        .wrap               (wrap),
        .err_overflow       (err_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; wave_line = '0; wave_valid = 1'b0; wave_last = 1'b0;
        run = 1'b0; halt = 1'b0; dac_rdy = 1'b0;
        bram_valid_line_out = 1'b0; bram_write_rdy = 1'b1;

        // Reset held for three cycles.
        repeat (3) tick();
        check("rst_we", bram_we, 0);
        check("rst_en", bram_en, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_line", bram_line_in, 0);
        check("rst_gen_mode", bram_gen_mode, 0);
        check("rst_rst_gen", bram_rst_gen_mode, 1);
        check("rst_next", bram_next, 0);
        check("rst_loaded", loaded, 0);
        check("rst_playing", playing, 0);
        check("rst_num_lines", num_lines, 0);
        check("rst_wrap", wrap, 0);
        check("rst_err", err_overflow, 0);
        check("rst_ready_hi", wave_ready, 1);
        bram_write_rdy = 1'b0; settle();
        check("rst_ready_lo", wave_ready, 0);
        bram_write_rdy = 1'b1;
        rst = 1'b0;
        tick();
        check("post_rst_gen_1", bram_rst_gen_mode, 1);
        tick();
        check("post_rst_gen_0", bram_rst_gen_mode, 0);

        // Load 5 lines 0xA0..0xA4, last on the fifth beat.
        for (int i = 0; i < 5; i++) begin
            wave_line  = DATA_WIDTH'(32'hA0 + i);
            wave_valid = 1'b1;
            wave_last  = (i == 4);
            settle();
            check("load_ready", wave_ready, 1);
            tick();
            check("load_we", bram_we, 1);
            check("load_en", bram_en, 1);
            check("load_addr", bram_addr, i);
            check("load_data", bram_line_in, 32'hA0 + i);
        end
        wave_valid = 1'b0; wave_last = 1'b0;
        check("load_loaded", loaded, 1);
        check("load_num_lines", num_lines, 5);
        check("load_err", err_overflow, 0);
        tick();
        check("load_we_idle", bram_we, 0);

        // run beats a simultaneous valid beat.
        run = 1'b1; wave_valid = 1'b1; wave_line = DATA_WIDTH'(32'hEE);
        settle();
        check("run_ready_lo", wave_ready, 0);
        check("run_gen_pre", bram_gen_mode, 0);
        tick();
        wave_valid = 1'b0;
        check("run_gen_mode", bram_gen_mode, 1);
        check("run_playing", playing, 1);
        check("run_no_write", bram_we, 0);
        check("run_loaded", loaded, 1);

        // Twelve nexts; wrap on the 5th and 10th.
        dac_rdy = 1'b1; bram_valid_line_out = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            settle();
            check("play_next", bram_next, 1);
            check("play_wrap", wrap, (c == 5 || c == 10));
            tick();
        end
        dac_rdy = 1'b0; settle();
        check("play_next_gated", bram_next, 0);
        check("play_ready_lo", wave_ready, 0);
        tick();

        // halt with a next in flight, then flush and re-enter PLAY.
        dac_rdy = 1'b1; halt = 1'b1; settle();
        check("halt_next", bram_next, 1);
        check("halt_wrap", wrap, 0);
        tick();
        halt = 1'b0; settle();
        check("flush_gen_mode", bram_gen_mode, 0);
        check("flush_rst_gen", bram_rst_gen_mode, 1);
        check("flush_playing", playing, 0);
        check("flush_next", bram_next, 0);
        tick();
        check("flush_rst_gen_off", bram_rst_gen_mode, 0);
        tick(); tick(); tick();
        check("flush_to_loaded_playing", playing, 0);
        check("flush_to_loaded_next", bram_next, 0);
        check("flush_loaded", loaded, 1);
        tick();
        check("replay_playing", playing, 1);
        check("replay_gen_mode", bram_gen_mode, 1);
        for (int k = 1; k <= 5; k++) begin
            settle();
            check("replay_wrap", wrap, (k == 5));
            tick();
        end

        // Stop by dropping run; back to LOADED after the flush.
        run = 1'b0; dac_rdy = 1'b0; bram_valid_line_out = 1'b0;
        repeat (5) tick();
        check("stop_playing", playing, 0);
        check("stop_loaded", loaded, 1);
        check("stop_ready", wave_ready, 1);

        // 610 beats without last: truncation at 600 lines.
        wave_valid = 1'b1; wave_last = 1'b0;
        for (int i = 0; i < 600; i++) begin
            wave_line = DATA_WIDTH'(32'h1000 + i);
            tick();
            check("ovf_addr", bram_addr, i);
            check("ovf_data", bram_line_in, 32'h1000 + i);
            if (i == 598) check("ovf_not_loaded", loaded, 0);
        end
        settle();
        check("ovf_err", err_overflow, 1);
        check("ovf_num_lines", num_lines, 600);
        check("ovf_loaded", loaded, 1);
        check("ovf_ready", wave_ready, 1);
        wave_line = DATA_WIDTH'(32'h601);
        tick();
        check("ovf_restart_we", bram_we, 1);
        check("ovf_restart_addr", bram_addr, 0);
        check("ovf_restart_loaded", loaded, 0);
        check("ovf_restart_err", err_overflow, 0);
        for (int i = 1; i < 10; i++) begin
            wave_line = DATA_WIDTH'(32'h601 + i);
            tick();
        end
        check("ovf_tail_addr", bram_addr, 9);

        // Close the load, start playing, then reset mid-play.
        wave_last = 1'b1; wave_line = DATA_WIDTH'(32'h77);
        tick();
        wave_valid = 1'b0; wave_last = 1'b0;
        check("close_addr", bram_addr, 10);
        check("close_num_lines", num_lines, 11);
        run = 1'b1;
        tick();
        check("rplay_playing", playing, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_playing", playing, 0);
        check("midrst_gen_mode", bram_gen_mode, 0);
        check("midrst_loaded", loaded, 0);
        check("midrst_num_lines", num_lines, 0);
        check("midrst_rst_gen", bram_rst_gen_mode, 1);
        repeat (3) tick();
        check("idle_run_playing", playing, 0);
        check("idle_run_gen_mode", bram_gen_mode, 0);
        check("idle_run_ready", wave_ready, 1);

        // Single-line waveform.
        run = 1'b0; wave_valid = 1'b1; wave_last = 1'b1; wave_line = DATA_WIDTH'(32'h55);
        tick();
        wave_valid = 1'b0; wave_last = 1'b0;
        check("single_addr", bram_addr, 0);
        check("single_data", bram_line_in, 32'h55);
        check("single_num_lines", num_lines, 1);
        check("single_loaded", loaded, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dense_bram_seq_ctrl.md
Name: dense_bram_seq_ctrl

Overview:
- Sequencing controller in front of the dense-waveform BRAM wrapper.
- Accepts a waveform as a valid/ready stream of lines and writes them to consecutive BRAM addresses from 0.
- Switches the wrapper into generator mode for playback, issuing one `next` per line consumed by the DAC side.
- Owns the mode handover and flush: stop, reset the generator address, return to a loaded state.

Parameters:
- DATA_WIDTH, 257, width of one BRAM line.
- BRAM_DEPTH, 600, number of BRAM lines; AW = $clog2(BRAM_DEPTH).
- FLUSH_CYCLES, 4, cycles held in FLUSH after playback stops (covers BRAM read latency).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wave_line  in  DATA_WIDTH  incoming waveform line.
- wave_valid  in  1  wave_line valid.
- wave_last  in  1  marks final line of the waveform; qualified by wave_valid.
- wave_ready  out  1  controller accepts wave_line this cycle.
- run  in  1  level; request playback.
- halt  in  1  pulse; stop playback.
- dac_rdy  in  1  consumer takes the current generator line.
- bram_addr  out  AW  write address to wrapper.
- bram_line_in  out  DATA_WIDTH  write data to wrapper.
- bram_we  out  1  write enable.
- bram_en  out  1  port enable.
- bram_gen_mode  out  1  generator-mode select.
- bram_rst_gen_mode  out  1  generator address reset.
- bram_next  out  1  advance generator.
- bram_valid_line_out  in  1  wrapper line valid.
- bram_write_rdy  in  1  wrapper ready for writes.
- loaded  out  1  a complete waveform is resident.
- playing  out  1  in PLAY.
- num_lines  out  AW+1  lines in resident waveform.
- wrap  out  1  one-cycle pulse when playback passes the last line.
- err_overflow  out  1  sticky: waveform truncated at BRAM_DEPTH.

Behaviour:
- States: IDLE, LOAD, LOADED, PLAY, FLUSH.
- Reset values:
  - All outputs 0 except bram_rst_gen_mode = 1.
  - bram_rst_gen_mode is held 1 during rst and for the first cycle after rst deasserts.
  - Internal wr_ptr = 0, play_cnt = 0, state = IDLE.
- Reset mid-operation: abort immediately to IDLE; num_lines, loaded and err_overflow are cleared; generator mode is dropped.
- wave_ready = bram_write_rdy && state ∈ {IDLE, LOAD, LOADED} && !(state==LOADED && run). Combinational.
- Write handshake:
  - On wave_valid && wave_ready, the next cycle drives bram_we = bram_en = 1, bram_addr = wr_ptr and bram_line_in = wave_line (1-cycle registered latency). wr_ptr then increments.
  - bram_we and bram_en are 0 on all other cycles.
- Start of load: an accept in IDLE or LOADED restarts at wr_ptr = 0, clears loaded, and enters LOAD.
- End of load:
  - Accept with wave_last: num_lines = wr_ptr+1, loaded = 1, go to LOADED.
  - Accept at wr_ptr == BRAM_DEPTH-1 without wave_last: same as last, and err_overflow is set (sticky until rst or next load start).
  - A single-line waveform (last on first beat) gives num_lines = 1.
- LOADED && run: go to PLAY. run wins over a simultaneous wave_valid.
- PLAY:
  - bram_gen_mode = 1 and playing = 1, both registered, asserted the cycle PLAY is entered.
  - bram_next = dac_rdy && bram_valid_line_out. Combinational, PLAY only.
  - Each next increments play_cnt. At play_cnt == num_lines-1, play_cnt wraps to 0 and wrap pulses on that cycle.
- Leaving PLAY:
  - halt, or run low, goes to FLUSH on the next edge.
  - halt takes priority over an in-flight next; that next still counts.
- FLUSH:
  - bram_gen_mode = 0 and bram_rst_gen_mode = 1 on the first FLUSH cycle only.
  - Hold FLUSH_CYCLES cycles, reset play_cnt, then go to LOADED. run is ignored during FLUSH.
  - If run is still high on return, re-enter PLAY.
- LOAD is never interrupted by run. Writes are never issued while bram_gen_mode = 1.

Test Plan:
- rst 3 cycles then release -> all outputs 0; bram_rst_gen_mode = 1 through the first post-reset cycle; wave_ready follows bram_write_rdy.
- Load 5 lines with values 0xA0..0xA4, last on the 5th beat, then run = 1 -> bram_we pulses at addr 0..4 with matching data; loaded = 1, num_lines = 5; bram_gen_mode rises one cycle after run.
- Play with dac_rdy = 1 and bram_valid_line_out = 1 for 12 cycles -> 12 bram_next pulses; wrap pulses on the 5th and 10th.
- Assert halt mid-play -> FLUSH: bram_gen_mode = 0, one-cycle bram_rst_gen_mode, LOADED after 4 cycles; run still high re-enters PLAY with play_cnt = 0.
- Stream 610 lines with no wave_last, BRAM_DEPTH = 600 -> writes to addr 0..599; err_overflow = 1, num_lines = 600, LOADED entered; wave_ready stays high, but beat 601 starts a new load at addr 0.
- Assert rst during PLAY -> next cycle IDLE; gen_mode = 0, loaded = 0, num_lines = 0; a subsequent run with no load causes no state change.
